// File: rtl/rename_map_pkg.sv
// Shared definitions for the register-rename map: index-width helpers,
// default index typedefs and the identity mapping loaded at reset.
package rename_pkg;

  // Bits needed to index n entries (at least one bit).
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Width of an architectural register index.
  function automatic int aw_of(input int arch_regs);
    return idx_width(arch_regs);
  endfunction

  // Width of a physical register index.
  function automatic int pw_of(input int phys_regs);
    return idx_width(phys_regs);
  endfunction

  localparam int ARCH_REGS_DEF = 8;
  localparam int PHYS_REGS_DEF = 16;

  typedef logic [aw_of(ARCH_REGS_DEF)-1:0] arch_idx_t;
  typedef logic [pw_of(PHYS_REGS_DEF)-1:0] phys_idx_t;

  // Physical register that architectural register 'arch' maps to after reset.
  function automatic int reset_phys(input int arch);
    return arch;
  endfunction

endpackage

// File: rtl/rename_map_if.sv
// Decode/dispatch-side bundle of the rename map: source lookups, destination
// rename handshake, commit and flush. The master is the pipeline front end.
interface rename_map_if #(
  parameter int ARCH_REGS  = 8,
  parameter int PHYS_REGS  = 16,
  parameter int READ_PORTS = 2
);
  import rename_pkg::*;

  localparam int AW = aw_of(ARCH_REGS);
  localparam int PW = pw_of(PHYS_REGS);

  logic [READ_PORTS-1:0]         rd_valid;
  logic [READ_PORTS-1:0][AW-1:0] rd_arch;
  logic [READ_PORTS-1:0][PW-1:0] rd_phys;

  logic          ren_valid;
  logic [AW-1:0] ren_arch;
  logic          ren_ready;
  logic [PW-1:0] ren_phys;
  logic [PW-1:0] ren_old_phys;

  logic          commit_valid;
  logic [AW-1:0] commit_arch;
  logic [PW-1:0] commit_phys;

  logic          flush;
  logic [PW:0]   free_count;

  modport master (
    output rd_valid, rd_arch, ren_valid, ren_arch,
           commit_valid, commit_arch, commit_phys, flush,
    input  rd_phys, ren_ready, ren_phys, ren_old_phys, free_count
  );

  modport slave (
    input  rd_valid, rd_arch, ren_valid, ren_arch,
           commit_valid, commit_arch, commit_phys, flush,
    output rd_phys, ren_ready, ren_phys, ren_old_phys, free_count
  );

endinterface

// File: rtl/rename_map_lowbit_enc.sv
// Lowest-set-bit priority encoder with a found flag; picks the next free
// physical register out of the free vector.
module lowbit_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register-rename map with integrated free list. Sources are translated through
// the speculative map, destinations take the lowest free physical register,
// commit frees the superseded committed mapping, and flush copies the committed
// map (including a same-cycle commit) back into the speculative map.
module rename_map
  import rename_pkg::*;
#(
  parameter int ARCH_REGS  = 8,
  parameter int PHYS_REGS  = 16,
  parameter int READ_PORTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  rename_map_if.slave   bus
);

  localparam int AW = aw_of(ARCH_REGS);
  localparam int PW = pw_of(PHYS_REGS);
  localparam logic [PW:0] FREE_INIT = (PW + 1)'(PHYS_REGS - ARCH_REGS);

  logic [PW-1:0]        spec_map_r       [ARCH_REGS];
  logic [PW-1:0]        commit_map_r     [ARCH_REGS];
  logic [PW-1:0]        commit_map_nxt_s [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_vec_r;
  logic [PHYS_REGS-1:0] free_vec_nxt_s;
  logic [PHYS_REGS-1:0] used_s;
  logic [PW:0]          free_count_r;
  logic [PW:0]          free_count_nxt_s;
  logic [PW-1:0]        alloc_idx_s;
  logic                 alloc_found_s;
  logic                 fire_s;

  lowbit_enc #(
    .N (PHYS_REGS),
    .W (PW)
  ) u_lowbit_enc (
    .vec   (free_vec_r),
    .idx   (alloc_idx_s),
    .found (alloc_found_s)
  );

  // Allocation is blocked during flush so a dropped rename cannot leak a register.
  assign bus.ren_ready    = alloc_found_s && !bus.flush;
  assign bus.ren_phys     = alloc_idx_s;
  assign bus.ren_old_phys = spec_map_r[bus.ren_arch];
  assign bus.free_count   = free_count_r;
  assign fire_s           = bus.ren_valid && bus.ren_ready;

  // Source lookups read the pre-rename speculative map; disabled ports return zero.
  always_comb begin
    for (int k = 0; k < READ_PORTS; k++) begin
      if (bus.rd_valid[k]) begin
        bus.rd_phys[k] = spec_map_r[bus.rd_arch[k]];
      end else begin
        bus.rd_phys[k] = '0;
      end
    end
  end

  // Committed map after this cycle's commit; flush restores from this value.
  always_comb begin
    commit_map_nxt_s = commit_map_r;
    if (bus.commit_valid) begin
      commit_map_nxt_s[bus.commit_arch] = bus.commit_phys;
    end else begin
      commit_map_nxt_s = commit_map_r;
    end
  end

  // Free-list and free-count next state for flush, commit and rename.
  always_comb begin
    used_s = '0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      used_s[commit_map_nxt_s[i]] = 1'b1;
    end
    free_vec_nxt_s   = free_vec_r;
    free_count_nxt_s = free_count_r;
    if (bus.flush) begin
      free_vec_nxt_s   = ~used_s;
      free_count_nxt_s = FREE_INIT;
    end else begin
      // The freed register is committed-mapped and hence never the one allocated now.
      if (bus.commit_valid) begin
        free_vec_nxt_s[commit_map_r[bus.commit_arch]] = 1'b1;
      end else begin
        free_vec_nxt_s = free_vec_nxt_s;
      end
      if (fire_s) begin
        free_vec_nxt_s[alloc_idx_s] = 1'b0;
      end else begin
        free_vec_nxt_s = free_vec_nxt_s;
      end
      free_count_nxt_s = free_count_r + (PW + 1)'(bus.commit_valid) - (PW + 1)'(fire_s);
    end
  end

  // Committed map, free list and free count state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        commit_map_r[i] <= PW'(reset_phys(i));
      end
      for (int j = 0; j < PHYS_REGS; j++) begin
        free_vec_r[j] <= (j >= ARCH_REGS) ? 1'b1 : 1'b0;
      end
      free_count_r <= FREE_INIT;
    end else begin
      commit_map_r <= commit_map_nxt_s;
      free_vec_r   <= free_vec_nxt_s;
      free_count_r <= free_count_nxt_s;
    end
  end

  // Speculative map: flush restores the committed view, otherwise a fired rename updates one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map_r[i] <= PW'(reset_phys(i));
      end
    end else if (bus.flush) begin
      spec_map_r <= commit_map_nxt_s;
    end else if (fire_s) begin
      spec_map_r[bus.ren_arch] <= alloc_idx_s;
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: reset state, exhaustion, commit free,
// flush recovery, flush/rename and flush/commit interaction, reset override.
module tb_rename_map;
  import rename_pkg::*;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  rename_map_if #(.ARCH_REGS(8), .PHYS_REGS(16), .READ_PORTS(2)) bus ();

  rename_map #(.ARCH_REGS(8), .PHYS_REGS(16), .READ_PORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_valid     = 2'b00;
    bus.rd_arch[0]   = 3'd0;
    bus.rd_arch[1]   = 3'd0;
    bus.ren_valid    = 1'b0;
    bus.ren_arch     = 3'd0;
    bus.commit_valid = 1'b0;
    bus.commit_arch  = 3'd0;
    bus.commit_phys  = 4'd0;
    bus.flush        = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    bus.rd_valid   = 2'b01;
    bus.rd_arch[0] = 3'd3;
    bus.rd_arch[1] = 3'd5;
    #1;
    chk("reset_rd_arch3", 32'(bus.rd_phys[0]), 32'd3);
    chk("reset_rd_invalid_zero", 32'(bus.rd_phys[1]), 32'd0);
    chk("reset_ren_phys", 32'(bus.ren_phys), 32'd8);
    chk("reset_free_count", 32'(bus.free_count), 32'd8);
    chk("reset_ren_ready", 32'(bus.ren_ready), 32'd1);

    // Eight renames of arch 2 drain the free list
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.ren_valid = 1'b1;
      bus.ren_arch  = 3'd2;
      #1;
      chk("drain_ren_phys", 32'(bus.ren_phys), 32'(8 + i));
      chk("drain_ren_old_phys", 32'(bus.ren_old_phys), (i == 0) ? 32'd2 : 32'(7 + i));
      chk("drain_ren_ready", 32'(bus.ren_ready), 32'd1);
      tick();
    end
    #1;
    chk("full_ren_ready", 32'(bus.ren_ready), 32'd0);
    chk("full_free_count", 32'(bus.free_count), 32'd0);
    tick();
    bus.ren_valid  = 1'b0;
    bus.rd_valid   = 2'b01;
    bus.rd_arch[0] = 3'd2;
    #1;
    chk("ninth_free_count", 32'(bus.free_count), 32'd0);
    chk("ninth_map_unchanged", 32'(bus.rd_phys[0]), 32'd15);

    // Commit arch 2 -> phys 8 frees phys 2, allocatable only next cycle
    bus.commit_valid = 1'b1;
    bus.commit_arch  = 3'd2;
    bus.commit_phys  = 4'd8;
    #1;
    chk("commit_same_cycle_not_ready", 32'(bus.ren_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("commit_ren_ready", 32'(bus.ren_ready), 32'd1);
    chk("commit_ren_phys", 32'(bus.ren_phys), 32'd2);
    chk("commit_free_count", 32'(bus.free_count), 32'd1);

    // Fresh reset, rename arch 1 twice, then flush
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ren_valid = 1'b1;
    bus.ren_arch  = 3'd1;
    tick();
    tick();
    bus.ren_valid = 1'b0;
    bus.flush     = 1'b1;
    #1;
    chk("flush_blocks_ready", 32'(bus.ren_ready), 32'd0);
    tick();
    idle();
    bus.rd_valid   = 2'b01;
    bus.rd_arch[0] = 3'd1;
    #1;
    chk("flush_rd_arch1", 32'(bus.rd_phys[0]), 32'd1);
    chk("flush_free_count", 32'(bus.free_count), 32'd8);
    chk("flush_ren_phys", 32'(bus.ren_phys), 32'd8);

    // Flush and rename of arch 5 together: rename dropped
    bus.flush     = 1'b1;
    bus.ren_valid = 1'b1;
    bus.ren_arch  = 3'd5;
    tick();
    idle();
    bus.rd_valid   = 2'b10;
    bus.rd_arch[1] = 3'd5;
    #1;
    chk("flush_ren_dropped_rd5", 32'(bus.rd_phys[1]), 32'd5);
    chk("flush_ren_dropped_count", 32'(bus.free_count), 32'd8);

    // Same-cycle read and rename of arch 4
    idle();
    bus.rd_valid   = 2'b01;
    bus.rd_arch[0] = 3'd4;
    bus.ren_valid  = 1'b1;
    bus.ren_arch   = 3'd4;
    #1;
    chk("bypass_rd_old", 32'(bus.rd_phys[0]), 32'd4);
    chk("bypass_ren_old_phys", 32'(bus.ren_old_phys), 32'd4);
    chk("bypass_ren_phys", 32'(bus.ren_phys), 32'd8);
    tick();
    bus.ren_valid = 1'b0;
    #1;
    chk("bypass_rd_new", 32'(bus.rd_phys[0]), 32'd8);
    chk("bypass_free_count", 32'(bus.free_count), 32'd7);
    chk("bypass_next_ren_phys", 32'(bus.ren_phys), 32'd9);

    // Flush with same-cycle commit of arch 4 -> phys 8: phys 4 becomes free
    bus.commit_valid = 1'b1;
    bus.commit_arch  = 3'd4;
    bus.commit_phys  = 4'd8;
    bus.flush        = 1'b1;
    tick();
    idle();
    bus.rd_valid   = 2'b01;
    bus.rd_arch[0] = 3'd4;
    #1;
    chk("flush_commit_rd4", 32'(bus.rd_phys[0]), 32'd8);
    chk("flush_commit_ren_phys", 32'(bus.ren_phys), 32'd4);
    chk("flush_commit_free_count", 32'(bus.free_count), 32'd8);

    // Reset overrides rename and commit in the same cycle
    bus.ren_valid    = 1'b1;
    bus.ren_arch     = 3'd0;
    bus.commit_valid = 1'b1;
    bus.commit_arch  = 3'd0;
    bus.commit_phys  = 4'd9;
    rst              = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    bus.rd_valid   = 2'b11;
    bus.rd_arch[0] = 3'd4;
    bus.rd_arch[1] = 3'd0;
    #1;
    chk("rst_override_rd4", 32'(bus.rd_phys[0]), 32'd4);
    chk("rst_override_rd0", 32'(bus.rd_phys[1]), 32'd0);
    chk("rst_override_free_count", 32'(bus.free_count), 32'd8);
    chk("rst_override_ren_phys", 32'(bus.ren_phys), 32'd8);

    // Commit and rename together without flush: count unchanged, phys 3 freed
    bus.ren_valid    = 1'b1;
    bus.ren_arch     = 3'd3;
    bus.commit_valid = 1'b1;
    bus.commit_arch  = 3'd3;
    bus.commit_phys  = 4'd8;
    tick();
    idle();
    bus.rd_valid   = 2'b01;
    bus.rd_arch[0] = 3'd3;
    #1;
    chk("both_free_count", 32'(bus.free_count), 32'd8);
    chk("both_ren_phys", 32'(bus.ren_phys), 32'd3);
    chk("both_rd3", 32'(bus.rd_phys[0]), 32'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
